block_memory: RTL and testbench
===============================

Name: block_memory

Overview:
- Word-organised main memory backing the 2-way write-back data cache.
- Transfers one whole 4-word (128-bit) block per access, selected by the block field of a 10-bit byte address.
- Reads are combinational; writes commit on the clock edge.
- The cache uses it for line fills (read) and dirty-line write-backs (write).

Parameters:
- ADDR_W, 10, byte address width.
- WORD_W, 32, word width in bits.
- BLOCK_WORDS, 4, words per block; block width = BLOCK_WORDS*WORD_W = 128.
- Derived constants:
  - MEM_WORDS = 2**ADDR_W/4 = 256.
  - NUM_BLOCKS = MEM_WORDS/BLOCK_WORDS = 64.

Ports:
- clk  input  1  single system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- read_write  input  1  0 = read block, 1 = write block.
- address  input  10  byte address.
  - Block index = address[9:4].
  - address[3:0] (word offset and byte offset) is ignored.
- writeData  input  128  block to store; word k is at bits [32k+31:32k].
- readData  output  128  block at address[9:4]; word k is at bits [32k+31:32k].

Behaviour:
- Storage: 256 x 32-bit words. Block b occupies words 4b..4b+3; word 4b+k maps to lane k.
- Reset (rst=1, asynchronous, takes effect immediately regardless of clk):
  - Every word i (0..255) is loaded with the value i, zero-extended to 32 bits.
  - The contents stay at these values for as long as rst is held; writes are ignored while rst=1.
- Read (default path, always active):
  - readData = block[address[9:4]], purely combinational, zero-cycle latency.
  - The output is valid in every cycle regardless of read_write.
  - During reset, readData reflects the reset contents.
- Write (read_write=1, rst=0, at the rising edge of clk):
  - All four words of block[address[9:4]] are replaced by writeData.
  - Other blocks are unchanged.
  - The new data is visible on readData immediately after that edge. Before the edge, readData shows the old contents.
- Back-to-back writes to the same block: the last write wins, one block update per edge.
- Write then read of the same block in the next cycle returns the written data; no forwarding is needed beyond the combinational read.
- read_write=1 with address changing mid-cycle: only the address present at the edge is written.
- Reset asserted between edges during a write: the pending write is discarded and the reset contents apply.
- No partial writes, no byte enables, no error signalling. Every address is in range and the address wraps naturally across the 10 bits.
- X or Z on read_write at an edge: treated as no write. Implement as "write only if read_write === 1"; synthesis treats this as ==1.

Optional Feature:
- Macro: MEM_REG_READ_EN.
- Defined:
  - readData is a register updated on every rising edge with block[address[9:4]] as it stands before that edge's write (read-before-write).
  - Read latency is 1 cycle.
  - readData resets asynchronously to 128'h0.
- Undefined: combinational read with zero latency, exactly as described above.
- The cache controller must wait one extra cycle for fills when the macro is defined.

Decomposition:
- Shared package mem_pkg holds:
  - constants ADDR_W, WORD_W, BLOCK_WORDS, MEM_WORDS, NUM_BLOCKS;
  - typedefs word_t (logic [31:0]) and block_t (logic [127:0]);
  - a function block_idx(addr) returning addr[9:4].
- The cache uses the same package.
- No sub-module: a single flat module with a word array plus a read mux.

Test Plan:
- Reset contents:
  - Stimulus: assert rst, release it, read address 10'h000, then address 10'h3F0.
  - Response: readData = {32'd3,32'd2,32'd1,32'd0}, then {32'd255,32'd254,32'd253,32'd252}.
- Offset ignored:
  - Stimulus: after reset, read addresses 10'h014 and 10'h01C.
  - Response: both give {32'd7,32'd6,32'd5,32'd4}.
- Write then read:
  - Stimulus: read_write=1, address=10'h120, writeData={32'hDDDD,32'hCCCC,32'hBBBB,32'hAAAA}, one edge; then read_write=0.
  - Response: readData is unchanged before the edge and equals the written block after it.
  - Neighbour check: block 10'h110 still reads {32'd71,32'd70,32'd69,32'd68}.
- Read_write low at the edge:
  - Stimulus: read_write=0 with writeData=all ones at address 10'h040 across 3 edges.
  - Response: block 4 stays {32'd19,32'd18,32'd17,32'd16}.
- Reset mid-operation:
  - Stimulus: write 10'h200 with all ones, then pulse rst between edges.
  - Response: readData for 10'h200 returns to {32'd131,32'd130,32'd129,32'd128} immediately, with no clock edge needed.
- With MEM_REG_READ_EN defined:
  - Stimulus: change address from 10'h000 to 10'h010.
  - Response: readData shows block 1 one edge later.
  - Stimulus: write block 2 and read block 2 on the same edge.
  - Response: readData returns the old block 2 contents on that edge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, types and address helper for the block memory and the data cache.
package mem_pkg;

  localparam int ADDR_W      = 10;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int MEM_WORDS   = (2 ** ADDR_W) / 4;
  localparam int NUM_BLOCKS  = MEM_WORDS / BLOCK_WORDS;
  localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;
  localparam int IDX_W       = 6;
  localparam int LANE_W      = 2;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  function automatic logic [IDX_W-1:0] block_idx(input logic [ADDR_W-1:0] addr);
    return addr[9:4];
  endfunction

endpackage

// File: rtl/block_memory.sv
// Word-organised main memory moving one 4-word block per access for the data cache.
// Define MEM_REG_READ_EN to register readData (1-cycle, read-before-write latency).
module block_memory
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] address,
  input  block_t            writeData,
  output block_t            readData
);

  word_t             mem_r [MEM_WORDS];
  logic [IDX_W-1:0]  idx_s;
  block_t            read_s;

  assign idx_s = block_idx(address);

  // Reset preloads word i with i; an unknown read_write never commits a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_r[i] <= word_t'(i);
      end
    end else if (read_write === 1'b1) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        mem_r[{idx_s, k[LANE_W-1:0]}] <= writeData[k*WORD_W +: WORD_W];
      end
    end
  end

  // Gather the four lanes of the addressed block.
  always_comb begin
    read_s = {BLOCK_W{1'b0}};
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      read_s[k*WORD_W +: WORD_W] = mem_r[{idx_s, k[LANE_W-1:0]}];
    end
  end

`ifdef MEM_REG_READ_EN
  // Capture the block as it stands before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData <= {BLOCK_W{1'b0}};
    end else begin
      readData <= read_s;
    end
  end
`else
  assign readData = read_s;
`endif

endmodule

// File: tb/tb_block_memory.sv
// Directed self-checking bench for block_memory (combinational or registered read build).
module tb_block_memory;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_write;
  logic [9:0]  address;
  block_t      writeData;
  block_t      readData;

  int checks   = 0;
  int failures = 0;

  localparam block_t ONES  = {128{1'b1}};
  localparam block_t DATA0 = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
  localparam block_t DATA1 = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
  localparam block_t DATA2 = {32'hCAFEF00D, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};

  block_memory dut (
    .clk        (clk),
    .rst        (rst),
    .read_write (read_write),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData)
  );

  always #5 clk = ~clk;

  task automatic check_block(input string tag, input block_t actual, input block_t expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    read_write = 1'b0;
    address    = 10'h000;
    writeData  = {128{1'b0}};
    #12;

`ifdef MEM_REG_READ_EN
    check_block("reg_reset_zero", readData, {128{1'b0}});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_block("reg_blk0", readData, {32'd3, 32'd2, 32'd1, 32'd0});
    @(negedge clk);
    address = 10'h010;
    #1;
    check_block("reg_blk1_pre_edge", readData, {32'd3, 32'd2, 32'd1, 32'd0});
    @(posedge clk); #1;
    check_block("reg_blk1_post_edge", readData, {32'd7, 32'd6, 32'd5, 32'd4});
    @(negedge clk);
    read_write = 1'b1;
    address    = 10'h020;
    writeData  = DATA0;
    @(posedge clk); #1;
    check_block("reg_rbw_old", readData, {32'd11, 32'd10, 32'd9, 32'd8});
    read_write = 1'b0;
    @(posedge clk); #1;
    check_block("reg_rbw_new", readData, DATA0);
    @(negedge clk);
    address = 10'h3F0;
    @(posedge clk); #1;
    check_block("reg_top_blk", readData, {32'd255, 32'd254, 32'd253, 32'd252});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_block("reg_async_reset", readData, {128{1'b0}});
    @(negedge clk);
    rst     = 1'b0;
    address = 10'h020;
    @(posedge clk); #1;
    check_block("reg_blk2_restored", readData, {32'd11, 32'd10, 32'd9, 32'd8});
`else
    check_block("reset_held_blk0", readData, {32'd3, 32'd2, 32'd1, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_block("reset_blk0", readData, {32'd3, 32'd2, 32'd1, 32'd0});
    address = 10'h3F0; #1;
    check_block("reset_blk63", readData, {32'd255, 32'd254, 32'd253, 32'd252});
    address = 10'h014; #1;
    check_block("offset_014", readData, {32'd7, 32'd6, 32'd5, 32'd4});
    address = 10'h01C; #1;
    check_block("offset_01c", readData, {32'd7, 32'd6, 32'd5, 32'd4});

    // Single block write, old contents visible until the edge
    @(negedge clk);
    read_write = 1'b1;
    address    = 10'h120;
    writeData  = DATA0;
    #1;
    check_block("write_pre_edge", readData, {32'd75, 32'd74, 32'd73, 32'd72});
    @(posedge clk); #1;
    check_block("write_post_edge", readData, DATA0);
    read_write = 1'b0;
    address = 10'h12C; #1;
    check_block("write_offset_read", readData, DATA0);
    address = 10'h110; #1;
    check_block("write_neighbour", readData, {32'd71, 32'd70, 32'd69, 32'd68});

    // Read-only cycles must never store writeData
    @(negedge clk);
    read_write = 1'b0;
    address    = 10'h040;
    writeData  = ONES;
    repeat (3) @(posedge clk);
    #1;
    check_block("read_no_store", readData, {32'd19, 32'd18, 32'd17, 32'd16});

    // Address moves mid-cycle: only the edge-time address is written
    @(negedge clk);
    read_write = 1'b1;
    address    = 10'h300;
    writeData  = DATA1;
    #2;
    address = 10'h310;
    @(posedge clk); #1;
    read_write = 1'b0;
    check_block("midcycle_new_addr", readData, DATA1);
    address = 10'h300; #1;
    check_block("midcycle_old_addr", readData, {32'd195, 32'd194, 32'd193, 32'd192});

    // Unknown read_write is not a write
    @(negedge clk);
    read_write = 1'bx;
    address    = 10'h0A0;
    writeData  = ONES;
    @(posedge clk); #1;
    read_write = 1'b0;
    check_block("x_rw_no_write", readData, {32'd43, 32'd42, 32'd41, 32'd40});

    // Back-to-back writes to the top block, last one wins
    @(negedge clk);
    read_write = 1'b1;
    address    = 10'h3F4;
    writeData  = DATA1;
    @(posedge clk); #1;
    check_block("b2b_first", readData, DATA1);
    @(negedge clk);
    writeData = DATA2;
    @(posedge clk); #1;
    read_write = 1'b0;
    address = 10'h3FF; #1;
    check_block("b2b_last_wins", readData, DATA2);

    // Asynchronous reset between edges restores initial contents
    @(negedge clk);
    read_write = 1'b1;
    address    = 10'h200;
    writeData  = ONES;
    @(posedge clk); #1;
    read_write = 1'b0;
    check_block("pre_reset_write", readData, ONES);
    #2;
    rst = 1'b1;
    #1;
    check_block("async_reset_blk32", readData, {32'd131, 32'd130, 32'd129, 32'd128});
    address = 10'h120; #1;
    check_block("async_reset_blk18", readData, {32'd75, 32'd74, 32'd73, 32'd72});
    read_write = 1'b1;
    address    = 10'h200;
    writeData  = ONES;
    @(posedge clk); #1;
    check_block("write_ignored_in_reset", readData, {32'd131, 32'd130, 32'd129, 32'd128});
    @(negedge clk);
    read_write = 1'b0;
    rst        = 1'b0;
    address    = 10'h3F0;
    #1;
    check_block("after_reset_blk63", readData, {32'd255, 32'd254, 32'd253, 32'd252});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
